// File: rtl/io_port_unit.sv
// Memory-mapped I/O buffer: a DEPTH-entry output FIFO toward the device and a
// one-entry input holding register toward the processor, with sticky error flags.
module io_port_unit #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] read_in,
    output logic             in_avail,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] hold_q;
    logic             in_avail_q, overflow_q, underflow_q;
    logic             push, pop, capture, consume;

    assign full      = (count_q == FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign out_data  = mem[rd_ptr_q];
    assign in_avail  = in_avail_q;
    assign in_ready  = ~in_avail_q;
    assign read_in   = in_avail_q ? hold_q : '0;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A store while full is dropped even if the head pops in the same cycle.
    assign push    = wr_en & ~full;
    assign pop     = out_valid & out_ready;
    assign capture = in_valid & ~in_avail_q;
    assign consume = rd_en & in_avail_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage has no reset so it maps onto plain RAM; stale contents are
    // unreachable once the pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_avail_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && !in_avail_q) begin
                underflow_q <= 1'b1;
            end
            if (capture) begin
                in_avail_q <= 1'b1;
            end else if (consume) begin
                in_avail_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (capture && !rst) begin
            hold_q <= in_data;
        end
    end
endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: output FIFO fill/overflow/drain/streaming,
// input holding register, underflow and mid-operation reset.
module tb_io_port_unit;
    logic        clock = 1'b0;
    logic        rst, wr_en, out_ready, in_valid, rd_en;
    logic [15:0] wr_data, in_data;
    logic        full, out_valid, in_ready, in_avail, overflow, underflow;
    logic [15:0] out_data, read_in;

    int checks = 0;
    int errors = 0;

    io_port_unit #(.DEPTH(4), .WIDTH(16)) dut (
        .clock(clock), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd_en(rd_en), .read_in(read_in), .in_avail(in_avail),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
        in_valid = 1'b0; in_data = '0; rd_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (in_avail !== 1'b0) begin errors++; $display("FAIL reset_in_avail: got %b want 0", in_avail); end
        checks++; if (read_in !== 16'h0) begin errors++; $display("FAIL reset_read_in: got %h want 0000", read_in); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", overflow, underflow); end
        $display("reset: full=%b out_valid=%b in_ready=%b read_in=%h", full, out_valid, in_ready, read_in);
    endtask

    task automatic test_fill();
        logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = vals[i];
            step();
            checks++; if (out_data !== 16'h1111 || out_valid !== 1'b1) begin errors++; $display("FAIL fill_head[%0d]: got %h/%b want 1111/1", i, out_data, out_valid); end
            checks++; if (full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 3)); end
            $display("fill push %h: full=%b head=%h", vals[i], full, out_data);
        end
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_overflow_drain();
        logic [15:0] exp [3] = '{16'h2222, 16'h3333, 16'h4444};
        wr_en = 1'b1; wr_data = 16'h5555; out_ready = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_after_pop: got %b want 0", full); end
        $display("overflow: flag=%b full=%b head=%h", overflow, full, out_data);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin errors++; $display("FAIL drain[%0d]: got %h/%b want %h/1", i, out_data, out_valid, exp[i]); end
            $display("drain word %h", out_data);
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1; wr_data = 16'(i);
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 16'(i)) begin errors++; $display("FAIL stream[%0d]: got %h/%b want %h/1", i, out_data, out_valid, 16'(i)); end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL stream_full[%0d]: got %b want 0", i, full); end
            $display("stream word %h", out_data);
        end
        wr_en = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_input();
        in_valid = 1'b1; in_data = 16'hBEEF;
        step();
        checks++; if (in_avail !== 1'b1 || read_in !== 16'hBEEF || in_ready !== 1'b0) begin errors++; $display("FAIL in_capture: got %b/%h/%b want 1/beef/0", in_avail, read_in, in_ready); end
        in_data = 16'hCAFE;
        step();
        checks++; if (read_in !== 16'hBEEF) begin errors++; $display("FAIL in_hold: got %h want beef", read_in); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (in_avail !== 1'b0 || read_in !== 16'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL in_consume: got %b/%h/%b want 0/0000/1", in_avail, read_in, in_ready); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL in_no_underflow: got %b want 0", underflow); end
        step();
        in_valid = 1'b0;
        checks++; if (in_avail !== 1'b1 || read_in !== 16'hCAFE) begin errors++; $display("FAIL in_second: got %b/%h want 1/cafe", in_avail, read_in); end
        $display("input: second word %h", read_in);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (in_avail !== 1'b0) begin errors++; $display("FAIL in_drain: got %b want 0", in_avail); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1 || read_in !== 16'h0) begin errors++; $display("FAIL udf_set: got %b/%h want 1/0000", underflow, read_in); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (underflow !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL udf_sticky[%0d]: got %b%b want 11", i, underflow, overflow); end
        end
        $display("underflow: sticky=%b read_in=%h", underflow, read_in);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234;
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; wr_data = 16'(i);
            step();
            in_valid = 1'b0;
        end
        wr_en = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_avail !== 1'b1 || out_data !== 16'h0001) begin errors++; $display("FAIL mid_preload: got %b/%b/%h want 1/1/0001", out_valid, in_avail, out_data); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_avail !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_state: got %b/%b/%b want 0/0/1", out_valid, in_avail, in_ready); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got %b%b%b want 000", overflow, underflow, full); end
        wr_en = 1'b1; wr_data = 16'h7777;
        step();
        wr_en = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h7777) begin errors++; $display("FAIL mid_push: got %h/%b want 7777/1", out_data, out_valid); end
        $display("reset mid-op: head after push %h", out_data);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_stream();
        test_input();
        test_underflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
